// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Pure declarations: no latency, no flow control.
package muldiv_pkg;

  localparam logic [1:0] MD_MULTU = 2'b00;
  localparam logic [1:0] MD_MULT  = 2'b01;
  localparam logic [1:0] MD_DIVU  = 2'b10;
  localparam logic [1:0] MD_DIV   = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, used for operand abs and result sign fix.
// Combinational, zero latency; no flow control.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one result bit per cycle, {hi, lo} result.
// Latency WIDTH+1 (divide-by-zero 1); holds EX via stallreq_o until the ready cycle, annul_i aborts.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   src1_i,
  input  logic [WIDTH-1:0]   src2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic               stallreq_o,
  output logic [2*WIDTH-1:0] result_o
);

  md_state_t          state_q;
  logic               div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               ready_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] result_q;

  logic               s1_neg;
  logic               s2_neg;
  logic [WIDTH-1:0]   src1_abs;
  logic [WIDTH-1:0]   src2_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [2*WIDTH-1:0] fixed_res;

  assign s1_neg = md_is_signed(op_i) & src1_i[WIDTH-1];
  assign s2_neg = md_is_signed(op_i) & src2_i[WIDTH-1];

  muldiv_signfix #(.W(WIDTH)) u_abs1 (.val_i(src1_i), .neg_i(s1_neg), .val_o(src1_abs));
  muldiv_signfix #(.W(WIDTH)) u_abs2 (.val_i(src2_i), .neg_i(s2_neg), .val_o(src2_abs));

  // Multiply keeps the multiplier in acc_q[lo]; divide keeps {rem, quot} in acc_q.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};

  always_comb begin
    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    if (div_q) begin
      if (div_trial[WIDTH]) begin
        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end
  end

  // Product is negated as one 2*WIDTH value; quotient and remainder independently.
  muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.val_i(acc_d), .neg_i(neg_q), .val_o(prod_fix));
  muldiv_signfix #(.W(WIDTH)) u_fix_quo (
    .val_i(acc_d[WIDTH-1:0]), .neg_i(neg_q), .val_o(quo_fix)
  );
  muldiv_signfix #(.W(WIDTH)) u_fix_rem (
    .val_i(acc_d[2*WIDTH-1:WIDTH]), .neg_i(rem_neg_q), .val_o(rem_fix)
  );

  assign fixed_res = div_q ? {rem_fix, quo_fix} : prod_fix;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= MD_IDLE;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      ready_q   <= 1'b0;
      cnt_q     <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      ready_q <= 1'b0;
      if (annul_i) begin
        state_q <= MD_IDLE;
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (start_i) begin
              div_q     <= md_is_div(op_i);
              neg_q     <= s1_neg ^ s2_neg;
              rem_neg_q <= s1_neg;
              cnt_q     <= CNT_W'(WIDTH);
              if (md_is_div(op_i)) begin
                opnd_q <= src2_abs;
                acc_q  <= {{WIDTH{1'b0}}, src1_abs};
              end else begin
                opnd_q <= src1_abs;
                acc_q  <= {{WIDTH{1'b0}}, src2_abs};
              end
              if (md_is_div(op_i) && (src2_i == '0)) begin
                state_q  <= MD_DONE;
                result_q <= {src1_i, {WIDTH{1'b1}}};
                ready_q  <= 1'b1;
              end else begin
                state_q <= MD_CALC;
              end
            end
          end
          MD_CALC: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q  <= MD_DONE;
              result_q <= fixed_res;
              ready_q  <= 1'b1;
            end
          end
          MD_DONE: state_q <= MD_IDLE;
          default: state_q <= MD_IDLE;
        endcase
      end
    end
  end

  assign busy_o     = (state_q == MD_CALC);
  assign ready_o    = ready_q;
  assign result_o   = result_q;
  assign stallreq_o = ((state_q == MD_IDLE) && start_i && !annul_i) || (state_q == MD_CALC);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit instance plus an 8-bit regression instance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i, annul_i;
  logic [1:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        busy_o, ready_o, stallreq_o;
  logic [63:0] result_o;

  logic        start8, annul8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, ready8, stall8;
  logic [15:0] res8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .annul_i(annul_i),
    .busy_o(busy_o), .ready_o(ready_o), .stallreq_o(stallreq_o), .result_o(result_o)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .start_i(start8), .op_i(op8),
    .src1_i(a8), .src2_i(b8), .annul_i(annul8),
    .busy_o(busy8), .ready_o(ready8), .stallreq_o(stall8), .result_o(res8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, hold start_i through DONE, then drop it in the first IDLE cycle.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
    int cyc, busy_cnt, stall_lo, extra;
    bit got;
    @(negedge clk);
    op_i = op; src1_i = a; src2_i = b; start_i = 1'b1;
    #1 check({tag, "_stall0"}, 64'(stallreq_o), 64'd1);
    cyc = 0; busy_cnt = 0; stall_lo = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (ready_o) begin
        got = 1'b1;
      end else begin
        if (busy_o) busy_cnt++;
        if (!stallreq_o) stall_lo++;
        if (cyc == 1) begin
          src1_i = ~a; src2_i = ~b; op_i = ~op;
        end
      end
    end
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_busycyc"}, 64'(busy_cnt), 64'(exp_lat - 1));
    check({tag, "_stall_calc"}, 64'(stall_lo), 64'd0);
    check({tag, "_stall_rdy"}, 64'(stallreq_o), 64'd0);
    @(negedge clk);
    check({tag, "_no_restart"}, 64'(busy_o), 64'd0);
    start_i = 1'b0;
    extra = 0;
    repeat (exp_lat + 3) begin
      @(negedge clk);
      if (ready_o) extra++;
    end
    check({tag, "_one_pulse"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int cyc, rdy;
    resetn = 1'b0; start_i = 1'b0; annul_i = 1'b0; op_i = 2'b00;
    src1_i = '0; src2_i = '0;
    start8 = 1'b0; annul8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #12;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_stall", 64'(stallreq_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    do_op("mult_neg",  MD_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 33);
    do_op("mult_mix",  MD_MULT,  32'h00000007, 32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFD6, 33);
    do_op("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_op("divu_big",  MD_DIVU,  32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33);
    do_op("div_pn",    MD_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    do_op("divu_zero", MD_DIVU,  32'h00001234, 32'h00000000, 64'h00001234_FFFFFFFF, 1);
    do_op("div_zero",  MD_DIV,   32'h80000000, 32'h00000000, 64'h80000000_FFFFFFFF, 1);
    do_op("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_op("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 33);

    // Annul in the middle of a divide.
    @(negedge clk);
    op_i = MD_DIVU; src1_i = 32'd100; src2_i = 32'd7; start_i = 1'b1;
    rdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("annul_busy_before", 64'(busy_o), 64'd1);
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_idle_busy", 64'(busy_o), 64'd0);
    check("annul_idle_stall", 64'(stallreq_o), 64'd0);
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("annul_no_ready", 64'(rdy), 64'd0);
    check("annul_result_kept", result_o, 64'hFFFFFFFE_00000001);

    do_op("divu_small", MD_DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 33);

    // Annul beats start in IDLE.
    @(negedge clk);
    op_i = MD_MULTU; src1_i = 32'd3; src2_i = 32'd3; start_i = 1'b1; annul_i = 1'b1;
    #1 check("annul_start_stall", 64'(stallreq_o), 64'd0);
    @(negedge clk);
    check("annul_start_busy", 64'(busy_o), 64'd0);
    start_i = 1'b0; annul_i = 1'b0;

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    op_i = MD_MULT; src1_i = 32'd7; src2_i = 32'hFFFFFFFA; start_i = 1'b1;
    repeat (5) @(negedge clk);
    check("rstmid_busy_before", 64'(busy_o), 64'd1);
    #2 resetn = 1'b0; start_i = 1'b0;
    #1;
    check("rstmid_busy", 64'(busy_o), 64'd0);
    check("rstmid_ready", 64'(ready_o), 64'd0);
    check("rstmid_stall", 64'(stallreq_o), 64'd0);
    check("rstmid_result", result_o, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    rdy = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) rdy++;
    end
    check("rstmid_no_ready", 64'(rdy), 64'd0);

    // WIDTH = 8 regression.
    @(negedge clk);
    op8 = MD_MULT; a8 = 8'hFD; b8 = 8'h05; start8 = 1'b1;
    #1 check("w8_stall0", 64'(stall8), 64'd1);
    cyc = 0; rdy = 0;
    while (rdy == 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (ready8) rdy = 1;
      else if (!busy8) rdy = 2;
    end
    start8 = 1'b0;
    check("w8_lat", 64'(cyc), 64'd9);
    check("w8_ready", 64'(rdy), 64'd1);
    check("w8_res", 64'(res8), 64'h000000000000FFF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that serves the EX stage for MULT/MULTU/DIV/DIVU. It computes one result bit per cycle and returns a {hi, lo} pair. The unit raises a stall request so the pipeline holds the instruction in EX until the result is ready. It replaces the fixed-width, combinationally driven divider with a parametrised unit that:
- covers both multiply and divide,
- has explicit annul,
- handles divide-by-zero deterministically.

## Interface
Clock: `clk`. Reset: `resetn`, asynchronous, active-low.

Parameters:
- `WIDTH`, default 32, operand width; even, ≥ 4.
- `CNT_W`, default `$clog2(WIDTH)+1`, iteration counter width; derived, not overridden.

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous active-low reset
- `start_i`  in  1  request operation; held by EX while its instruction stalls
- `op_i`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- `src1_i`  in  WIDTH  multiplicand / dividend
- `src2_i`  in  WIDTH  multiplier / divisor
- `annul_i`  in  1  abort current operation (flush)
- `busy_o`  out  1  state is CALC
- `ready_o`  out  1  one-cycle pulse, result valid
- `stallreq_o`  out  1  stall request to the pipeline controller
- `result_o`  out  2*WIDTH  {hi, lo}
  - mul: full product
  - div: {remainder, quotient}

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start_i` && !`annul_i` latches operands and op.
  - Signed ops latch absolute values plus sign flags.
  - Divisor == 0 (either div op) goes directly to DONE. Otherwise go to CALC with counter = WIDTH.
- CALC:
  - Multiply: shift-add. Each cycle conditionally add the multiplicand to the upper half of the 2*WIDTH accumulator, then shift right one.
  - Divide: restoring. Each cycle shift the {rem, quot} left one and trial-subtract the divisor. On no borrow, store the difference and set quotient LSB = 1.
  - Counter decrements each cycle. Go to DONE after the cycle in which the counter reaches 1.
- DONE:
  - Sign fix is applied and registered into `result_o`. `ready_o` = 1 for this cycle only.
  - Next state is IDLE unconditionally. `start_i` is ignored in DONE, so the still-held instruction does not restart.
- Sign rules:
  - MULT: product negated if operand signs differ.
  - DIV: quotient negated if signs differ; remainder takes the dividend's sign.
  - All arithmetic is modulo 2^WIDTH per half.
  - DIV MIN / −1 gives quotient = MIN, remainder = 0. No trap.
- Divide by zero: `result_o` = {`src1_i`, all-ones}, for both signed and unsigned.
- `annul_i`:
  - In any state, the next state is IDLE. No `ready_o` pulse; `result_o` unchanged.
  - In IDLE, annul beats start.
- `stallreq_o` = (IDLE && `start_i` && !`annul_i`) || CALC. It is 0 in DONE, so EX advances in the ready cycle.
- `result_o` holds its last value until the next DONE.

## Timing
- Reset values: state IDLE, `result_o` = 0, `busy_o`/`ready_o`/`stallreq_o` = 0, counter 0.
- Start accepted at cycle 0. `busy_o` is high for cycles 1..WIDTH. DONE/`ready_o` at cycle WIDTH+1, so latency = WIDTH+1.
- Divide by zero: `ready_o` at cycle 1.
- Back-to-back: a new start is accepted at cycle WIDTH+2 (first IDLE after DONE).
- Reset mid-operation: immediate return to the reset values, with no `ready_o`.
- Operands are sampled only at acceptance. Changes on `src*_i` during CALC have no effect.

## Structure
- Package `muldiv_pkg`:
  - op encodings `MD_MULTU`, `MD_MULT`, `MD_DIVU`, `MD_DIV`
  - state enum `md_state_t`
- One sub-module, `muldiv_signfix`: combinational conditional two's-complement negate (abs on entry, fix on exit). It is instantiated for the operand abs and for the result fix.
- Everything else is one always_ff FSM + datapath in `muldiv_unit`. The EX stage drives `start_i` from the decoded mul/div instruction bits.

## Test plan
- MULT 0xFFFFFFFD × 0x00000005 → `ready_o` at cycle 33, `result_o` = 0xFFFFFFFF_FFFFFFF1; `stallreq_o` high in cycles 0..32.
- DIV 0xFFFFFFF9 ÷ 0x00000002 → hi = 0xFFFFFFFF, lo = 0xFFFFFFFD. Repeat as DIVU → hi = 0x00000001, lo = 0x7FFFFFFC.
- DIVU 0x00001234 ÷ 0 → `ready_o` at cycle 1, `result_o` = 0x00001234_FFFFFFFF, `busy_o` never high.
- DIV 0x80000000 ÷ 0xFFFFFFFF → hi = 0, lo = 0x80000000; MULTU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE_00000001.
- DIVU 100 ÷ 7 with `annul_i` at cycle 10 → no `ready_o`, IDLE at cycle 11, `result_o` keeps its prior value. A following DIVU 100 ÷ 7 gives hi = 2, lo = 14.
- `resetn` low at cycle 5 of a MULT → all outputs 0 asynchronously. Holding `start_i` through the DONE cycle produces exactly one `ready_o` pulse. WIDTH = 8 regression: MULT 0xFD × 0x05 → 0xFFF1 at cycle 9.
